// File: rtl/fractal_sync_pkg.sv
// Shared types and default constants for the fractal_sync control unit.
package fractal_sync_pkg;

    // Control-unit barrier states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC  = 3'd1,
        WAIT  = 3'd2,
        ACK   = 3'd3,
        DRAIN = 3'd4,
        RSP   = 3'd5
    } cu_state_e;

    localparam int DEF_LVL_WIDTH      = 4;
    localparam int DEF_CNT_WIDTH      = 16;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/fractal_sync_cu.sv
// Per-core synchronization control unit. Converts a core barrier request
// into the sync -> wake -> ack handshake of a leaf fractal_sync node and
// returns a buffered response with error, timeout and latency information.
module fractal_sync_cu
    import fractal_sync_pkg::*;
#(
    parameter int LVL_WIDTH      = DEF_LVL_WIDTH,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [LVL_WIDTH-1:0] req_level_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_error_o,
    output logic [CNT_WIDTH-1:0] rsp_latency_o,
    output logic                 timeout_o,
    output logic [LVL_WIDTH-1:0] level_o,
    output logic                 sync_o,
    output logic                 ack_o,
    input  logic                 wake_i,
    input  logic                 error_i
);

    // Unsigned copy so the comparison against the counter stays unsigned
    localparam logic [31:0] TIMEOUT_U = TIMEOUT_CYCLES;

    cu_state_e            state_q, state_d;
    logic [LVL_WIDTH-1:0] level_q, level_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] lat_q, lat_d;
    logic                 err_q, err_d;
    logic                 timeout_q, timeout_d;

    logic accept;
    logic cnt_max;
    logic timeout_hit;

    assign accept      = (state_q == IDLE) && req_valid_i;
    assign cnt_max     = (cnt_q == {CNT_WIDTH{1'b1}});
    assign timeout_hit = (TIMEOUT_U != 32'd0) && (32'(cnt_q) == TIMEOUT_U);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; SYNC and ACK are single-cycle pulses
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i) state_d = SYNC;
            SYNC:    state_d = WAIT;
            WAIT:    if (wake_i) state_d = ACK;
            ACK:     state_d = DRAIN;
            DRAIN:   if (!wake_i) state_d = RSP;
            RSP:     if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        req_ready_o = 1'b0;
        sync_o      = 1'b0;
        ack_o       = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_q)
            IDLE:    req_ready_o = 1'b1;
            SYNC:    sync_o      = 1'b1;
            ACK:     ack_o       = 1'b1;
            RSP:     rsp_valid_o = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values: level latch, saturating WAIT counter, response capture
    always_comb begin
        level_d   = level_q;
        cnt_d     = cnt_q;
        lat_d     = lat_q;
        err_d     = err_q;
        timeout_d = timeout_q;
        if (accept) begin
            level_d   = req_level_i;
            cnt_d     = '0;
            err_d     = 1'b0;
            timeout_d = 1'b0;
        end else if (state_q == WAIT) begin
            if (timeout_hit) begin
                timeout_d = 1'b1;
            end
            if (wake_i) begin
                // Counter holds the number of full WAIT cycles before wake
                err_d = error_i;
                lat_d = cnt_q;
            end else if (!cnt_max) begin
                cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    // Datapath registers; reset clears everything so a new barrier starts clean
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_q   <= '0;
            cnt_q     <= '0;
            lat_q     <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            lat_q     <= lat_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
        end
    end

    assign level_o       = level_q;
    assign rsp_error_o   = err_q;
    assign rsp_latency_o = lat_q;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_fractal_sync_cu.sv
// Directed bench for fractal_sync_cu: a per-cycle vector table for the
// default configuration plus hand sequences for stall, timeout, counter
// saturation and mid-barrier reset. Three instances share the stimulus:
// default, TIMEOUT_CYCLES=8, and CNT_WIDTH=4 with timeout disabled.
module tb_fractal_sync_cu;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [3:0] req_level;
    logic       rsp_ready;
    logic       wake;
    logic       error;

    // default instance
    logic        ready_a, rv_a, err_a, to_a, sync_a, ack_a;
    logic [15:0] lat_a;
    logic [3:0]  lvl_a;
    // TIMEOUT_CYCLES = 8
    logic        ready_t, rv_t, err_t, to_t, sync_t, ack_t;
    logic [15:0] lat_t;
    logic [3:0]  lvl_t;
    // CNT_WIDTH = 4, timeout disabled
    logic        ready_s, rv_s, err_s, to_s, sync_s, ack_s;
    logic [3:0]  lat_s;
    logic [3:0]  lvl_s;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fractal_sync_cu dut_a (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(ready_a), .req_level_i(req_level),
        .rsp_valid_o(rv_a), .rsp_ready_i(rsp_ready), .rsp_error_o(err_a),
        .rsp_latency_o(lat_a), .timeout_o(to_a), .level_o(lvl_a),
        .sync_o(sync_a), .ack_o(ack_a), .wake_i(wake), .error_i(error)
    );

    fractal_sync_cu #(.TIMEOUT_CYCLES(8)) dut_t (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(ready_t), .req_level_i(req_level),
        .rsp_valid_o(rv_t), .rsp_ready_i(rsp_ready), .rsp_error_o(err_t),
        .rsp_latency_o(lat_t), .timeout_o(to_t), .level_o(lvl_t),
        .sync_o(sync_t), .ack_o(ack_t), .wake_i(wake), .error_i(error)
    );

    fractal_sync_cu #(.CNT_WIDTH(4), .TIMEOUT_CYCLES(0)) dut_s (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(ready_s), .req_level_i(req_level),
        .rsp_valid_o(rv_s), .rsp_ready_i(rsp_ready), .rsp_error_o(err_s),
        .rsp_latency_o(lat_s), .timeout_o(to_s), .level_o(lvl_s),
        .sync_o(sync_s), .ack_o(ack_s), .wake_i(wake), .error_i(error)
    );

    typedef struct {
        logic        vld;
        logic [3:0]  lvl;
        logic        rdy;
        logic        wk;
        logic        er;
        logic        e_ready;
        logic        e_sync;
        logic        e_ack;
        logic        e_rv;
        logic        e_err;
        logic [15:0] e_lat;
        logic [3:0]  e_lvl;
    } vec_t;

    localparam int NV = 31;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic vld, input logic [3:0] lvl, input logic rdy,
                                input logic wk, input logic er,
                                input logic e_ready, input logic e_sync, input logic e_ack,
                                input logic e_rv, input logic e_err,
                                input logic [15:0] e_lat, input logic [3:0] e_lvl);
        vec_t v;
        v.vld = vld; v.lvl = lvl; v.rdy = rdy; v.wk = wk; v.er = er;
        v.e_ready = e_ready; v.e_sync = e_sync; v.e_ack = e_ack;
        v.e_rv = e_rv; v.e_err = e_err; v.e_lat = e_lat; v.e_lvl = e_lvl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply inputs for one cycle, then sample at the falling edge
    task automatic cyc(input logic vld, input logic [3:0] lvl, input logic rdy,
                       input logic wk, input logic er);
        @(posedge clk);
        #1;
        req_valid = vld; req_level = lvl; rsp_ready = rdy; wake = wk; error = er;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = 1'b0; req_level = '0; rsp_ready = 1'b0;
        wake = 1'b0; error = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        //            vld lvl rdy wk er | rdy sync ack rv err lat lvl
        // barrier 1: wake cycles 5-6, latency 3, response in cycle 8
        tbl[0]  = mk(1, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 1);
        tbl[2]  = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1);
        tbl[3]  = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1);
        tbl[4]  = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1);
        tbl[5]  = mk(0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 1);
        tbl[6]  = mk(0, 0, 0, 1, 0,   0, 0, 1, 0, 0, 3, 1);
        tbl[7]  = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 3, 1);
        tbl[8]  = mk(0, 0, 1, 0, 0,   0, 0, 0, 1, 0, 3, 1);
        // barrier 2: minimum path, wake with error
        tbl[9]  = mk(1, 2, 0, 0, 0,   1, 0, 0, 0, 0, 3, 1);
        tbl[10] = mk(0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 3, 2);
        tbl[11] = mk(0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 3, 2);
        tbl[12] = mk(0, 0, 0, 0, 0,   0, 0, 1, 0, 1, 0, 2);
        tbl[13] = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 2);
        tbl[14] = mk(0, 0, 1, 0, 0,   0, 0, 0, 1, 1, 0, 2);
        // barrier 3: stray wake in IDLE/SYNC ignored, DRAIN holds while wake high
        tbl[15] = mk(1, 3, 0, 1, 0,   1, 0, 0, 0, 1, 0, 2);
        tbl[16] = mk(0, 0, 0, 1, 0,   0, 1, 0, 0, 0, 0, 3);
        tbl[17] = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 3);
        tbl[18] = mk(0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 3);
        tbl[19] = mk(0, 0, 0, 1, 0,   0, 0, 1, 0, 0, 1, 3);
        tbl[20] = mk(0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 1, 3);
        tbl[21] = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 3);
        tbl[22] = mk(1, 4, 0, 0, 0,   0, 0, 0, 1, 0, 1, 3);
        tbl[23] = mk(1, 4, 1, 0, 0,   0, 0, 0, 1, 0, 1, 3);
        // barrier 4: request held through the response handshake
        tbl[24] = mk(1, 4, 0, 0, 0,   1, 0, 0, 0, 0, 1, 3);
        tbl[25] = mk(0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 1, 4);
        tbl[26] = mk(0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 1, 4);
        tbl[27] = mk(0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 4);
        tbl[28] = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 4);
        tbl[29] = mk(0, 0, 1, 0, 0,   0, 0, 0, 1, 0, 0, 4);
        tbl[30] = mk(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 4);

        // ---- reset state ----
        rst = 1'b1; req_valid = 1'b0; req_level = '0; rsp_ready = 1'b0;
        wake = 1'b0; error = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs",
            {ready_a, sync_a, ack_a, rv_a, err_a, to_a, lvl_a, lat_a},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0});

        // ---- table-driven barrier vectors on the default instance ----
        for (int i = 0; i < NV; i++) begin
            cyc(tbl[i].vld, tbl[i].lvl, tbl[i].rdy, tbl[i].wk, tbl[i].er);
            n_vec++;
            if ({ready_a, sync_a, ack_a, rv_a, err_a, to_a, lvl_a, lat_a} !==
                {tbl[i].e_ready, tbl[i].e_sync, tbl[i].e_ack, tbl[i].e_rv, tbl[i].e_err,
                 1'b0, tbl[i].e_lvl, tbl[i].e_lat}) begin
                n_fail++;
                $display("FAIL row %0d: got rdy/sync/ack/rv/err/to/lvl/lat=%b%b%b%b%b%b/%h/%h expected %b%b%b%b%b0/%h/%h",
                         i, ready_a, sync_a, ack_a, rv_a, err_a, to_a, lvl_a, lat_a,
                         tbl[i].e_ready, tbl[i].e_sync, tbl[i].e_ack, tbl[i].e_rv,
                         tbl[i].e_err, tbl[i].e_lvl, tbl[i].e_lat);
            end
        end

        // ---- response stalled for 10 cycles with a request held high ----
        do_reset();
        cyc(1, 6, 0, 0, 0);
        chk("stall_accept_ready", ready_a, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 9, 0, 0, 0);
            chk("stall_hold",
                {ready_a, rv_a, err_a, lvl_a, lat_a},
                {1'b0, 1'b1, 1'b1, 4'd6, 16'd2});
        end
        cyc(1, 9, 1, 0, 0);
        chk("stall_handshake", {ready_a, rv_a}, {1'b0, 1'b1});
        cyc(1, 9, 0, 0, 0);
        chk("stall_next_accept", {ready_a, rv_a}, {1'b1, 1'b0});
        cyc(0, 0, 0, 0, 0);
        chk("stall_next_sync", {sync_a, lvl_a}, {1'b1, 4'd9});

        // ---- timeout after 8 WAIT cycles, wake at WAIT cycle 20 ----
        do_reset();
        cyc(1, 5, 0, 0, 0);
        chk("to_accept", ready_t, 1);
        cyc(0, 0, 0, 0, 0);
        chk("to_sync", {sync_t, to_t}, {1'b1, 1'b0});
        for (int j = 0; j < 20; j++) begin
            cyc(0, 0, 0, 0, 0);
            chk($sformatf("to_wait_%0d", j), to_t, (j >= 9) ? 1 : 0);
        end
        cyc(0, 0, 0, 1, 0);
        chk("to_wake", to_t, 1);
        cyc(0, 0, 0, 0, 0);
        chk("to_ack", {ack_t, to_t, lat_t}, {1'b1, 1'b1, 16'd20});
        chk("to_default_inst", to_a, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("to_rsp", {rv_t, to_t, err_t, lat_t}, {1'b1, 1'b1, 1'b0, 16'd20});
        cyc(1, 2, 0, 0, 0);
        chk("to_idle_still_set", {ready_t, to_t}, {1'b1, 1'b1});
        cyc(0, 0, 0, 0, 0);
        chk("to_cleared_on_accept", {sync_t, to_t}, {1'b1, 1'b0});

        // ---- counter saturation with CNT_WIDTH=4, wake after 40 cycles ----
        do_reset();
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        for (int j = 0; j < 40; j++) begin
            cyc(0, 0, 0, 0, 0);
        end
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        chk("sat_ack_lat", {ack_s, lat_s}, {1'b1, 4'd15});
        chk("sat_full_width_lat", lat_a, 40);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("sat_rsp", {rv_s, lat_s, to_s}, {1'b1, 4'd15, 1'b0});
        chk("sat_timeout_set_8", to_t, 1);

        // ---- reset in WAIT aborts the barrier; late wake ignored ----
        cyc(1, 7, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_pre_wait", {ready_a, sync_a, lvl_a}, {1'b0, 1'b0, 4'd7});
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_outputs",
            {ready_a, sync_a, ack_a, rv_a, err_a, to_a, lvl_a, lat_a},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0});
        chk("rst_mid_sat_lat", {lat_s, ready_s}, {4'd0, 1'b1});
        cyc(0, 0, 0, 1, 0);
        chk("rst_late_wake", {ack_a, ready_a, sync_a}, {1'b0, 1'b1, 1'b0});
        cyc(0, 0, 0, 0, 0);
        chk("rst_late_wake_after", {ack_a, ready_a, rv_a}, {1'b0, 1'b1, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
